// File: rtl/page_stream_adapter_if.sv
// Stream bundle between the leaf interface, the page adapter and the user kernel.
// The slave modport is the adapter's view; master is the environment around it
// (leaf interface on the if_* side, kernel on the k_* side).
interface page_stream_adapter_if #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1
);
    // leaf interface -> kernel direction
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  if_dout;
    logic [NUM_IN_PORTS-1:0]               if_vld;
    logic [NUM_IN_PORTS-1:0]               if_ack;
    logic [NUM_IN_PORTS*PAYLOAD_BITS-1:0]  k_din;
    logic [NUM_IN_PORTS-1:0]               k_din_vld;
    logic [NUM_IN_PORTS-1:0]               k_din_ack;

    // kernel -> leaf interface direction
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] k_dout;
    logic [NUM_OUT_PORTS-1:0]              k_dout_vld;
    logic [NUM_OUT_PORTS-1:0]              k_dout_ack;
    logic [NUM_OUT_PORTS*PAYLOAD_BITS-1:0] if_din;
    logic [NUM_OUT_PORTS-1:0]              if_din_vld;
    logic [NUM_OUT_PORTS-1:0]              if_din_ack;

    modport master (
        output if_dout, if_vld, k_din_ack, k_dout, k_dout_vld, if_din_ack,
        input  if_ack, k_din, k_din_vld, k_dout_ack, if_din, if_din_vld
    );

    modport slave (
        input  if_dout, if_vld, k_din_ack, k_dout, k_dout_vld, if_din_ack,
        output if_ack, k_din, k_din_vld, k_dout_ack, if_din, if_din_vld
    );
endinterface

// File: rtl/page_stream_adapter.sv
// Buffering adapter between leaf-interface user streams and a page kernel.
// Every channel owns an independent DEPTH-word FIFO; ready/valid are derived
// from the registered occupancy only, so no combinational path crosses a FIFO.
// Also provides per-channel transfer counters, a sticky kernel start and idle.
module page_stream_adapter #(
    parameter int PAYLOAD_BITS  = 32,
    parameter int NUM_IN_PORTS  = 1,
    parameter int NUM_OUT_PORTS = 1,
    parameter int DEPTH_BITS    = 3,
    parameter int CNT_BITS      = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              ap_start,
    input  logic                              clear_cnt,
    page_stream_adapter_if.slave              bus,
    output logic                              kernel_start,
    output logic [NUM_IN_PORTS*CNT_BITS-1:0]  in_cnt,
    output logic [NUM_OUT_PORTS*CNT_BITS-1:0] out_cnt,
    output logic                              idle
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [NUM_IN_PORTS-1:0]  in_empty;
    logic [NUM_OUT_PORTS-1:0] out_empty;
    logic                     kernel_start_q;

    // Leaf interface -> kernel channels
    for (genvar gi = 0; gi < NUM_IN_PORTS; gi++) begin : g_in
        logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
        logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
        logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
        logic [DEPTH_BITS:0]     count_q, count_d;
        logic [CNT_BITS-1:0]     xfer_cnt_q, xfer_cnt_d;
        logic                    full, empty, push, pop;

        // count only reaches DEPTH when full, so its MSB is the full flag
        assign full  = count_q[DEPTH_BITS];
        assign empty = (count_q == '0);
        assign push  = bus.if_vld[gi] & ~full;
        assign pop   = bus.k_din_ack[gi] & ~empty;

        assign bus.if_ack[gi]    = ~full;
        assign bus.k_din_vld[gi] = ~empty;
        assign bus.k_din[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];
        assign in_cnt[gi*CNT_BITS +: CNT_BITS] = xfer_cnt_q;
        assign in_empty[gi] = empty;

        // Next pointers, occupancy and delivered-word counter
        always_comb begin
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            count_d    = count_q;
            xfer_cnt_d = xfer_cnt_q;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (clear_cnt)  xfer_cnt_d = '0;
            else if (pop)   xfer_cnt_d = xfer_cnt_q + 1'b1;
        end

        // Control state; reset drops all buffered words at once
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                xfer_cnt_q <= '0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                xfer_cnt_q <= xfer_cnt_d;
            end
        end

        // Storage write; contents need no reset since occupancy gates reads
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= bus.if_dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // Kernel -> leaf interface channels
    for (genvar gi = 0; gi < NUM_OUT_PORTS; gi++) begin : g_out
        logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
        logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d;
        logic [DEPTH_BITS-1:0]   rd_ptr_q, rd_ptr_d;
        logic [DEPTH_BITS:0]     count_q, count_d;
        logic [CNT_BITS-1:0]     xfer_cnt_q, xfer_cnt_d;
        logic                    full, empty, push, pop;

        assign full  = count_q[DEPTH_BITS];
        assign empty = (count_q == '0);
        assign push  = bus.k_dout_vld[gi] & ~full;
        assign pop   = bus.if_din_ack[gi] & ~empty;

        assign bus.k_dout_ack[gi] = ~full;
        assign bus.if_din_vld[gi] = ~empty;
        assign bus.if_din[gi*PAYLOAD_BITS +: PAYLOAD_BITS] = mem_q[rd_ptr_q];
        assign out_cnt[gi*CNT_BITS +: CNT_BITS] = xfer_cnt_q;
        assign out_empty[gi] = empty;

        // Next pointers, occupancy and delivered-word counter
        always_comb begin
            wr_ptr_d   = wr_ptr_q;
            rd_ptr_d   = rd_ptr_q;
            count_d    = count_q;
            xfer_cnt_d = xfer_cnt_q;
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
            if (clear_cnt)  xfer_cnt_d = '0;
            else if (pop)   xfer_cnt_d = xfer_cnt_q + 1'b1;
        end

        // Control state; reset drops all buffered words at once
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                wr_ptr_q   <= '0;
                rd_ptr_q   <= '0;
                count_q    <= '0;
                xfer_cnt_q <= '0;
            end else begin
                wr_ptr_q   <= wr_ptr_d;
                rd_ptr_q   <= rd_ptr_d;
                count_q    <= count_d;
                xfer_cnt_q <= xfer_cnt_d;
            end
        end

        // Storage write
        always_ff @(posedge clk) begin
            if (push) mem_q[wr_ptr_q] <= bus.k_dout[gi*PAYLOAD_BITS +: PAYLOAD_BITS];
        end
    end

    // Sticky kernel start: latched on the first sampled ap_start
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)        kernel_start_q <= 1'b0;
        else if (ap_start) kernel_start_q <= 1'b1;
    end

    assign kernel_start = kernel_start_q;
    assign idle         = (&in_empty) & (&out_empty);
endmodule

// File: tb/tb_page_stream_adapter.sv
// Directed bench for page_stream_adapter: a cycle table on input channel 0
// plus hand-written sequences for start, clear, multi-channel and reset.
module tb_page_stream_adapter;
    localparam int PB = 32, NI = 2, NO = 3, DB = 3, CB = 8;

    logic clk = 1'b0;
    logic reset, ap_start, clear_cnt;
    logic kernel_start, idle;
    logic [NI*CB-1:0] in_cnt;
    logic [NO*CB-1:0] out_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    page_stream_adapter_if #(.PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO)) bus ();

    page_stream_adapter #(
        .PAYLOAD_BITS(PB), .NUM_IN_PORTS(NI), .NUM_OUT_PORTS(NO),
        .DEPTH_BITS(DB), .CNT_BITS(CB)
    ) dut (
        .clk(clk), .reset(reset), .ap_start(ap_start), .clear_cnt(clear_cnt),
        .bus(bus), .kernel_start(kernel_start), .in_cnt(in_cnt),
        .out_cnt(out_cnt), .idle(idle)
    );

    typedef struct {
        logic        vld;
        logic [31:0] data;
        logic        kack;
        logic        exp_ack;
        logic        exp_kvld;
        logic [31:0] exp_kdin;
        logic [7:0]  exp_cnt;
        logic        exp_idle;
    } vec_t;

    vec_t tbl [23];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input logic vld, input logic [31:0] d, input logic kack,
                                input logic ea, input logic ekv, input logic [31:0] ekd,
                                input logic [7:0] ec, input logic ei);
        vec_t v;
        v.vld = vld; v.data = d; v.kack = kack; v.exp_ack = ea; v.exp_kvld = ekv;
        v.exp_kdin = ekd; v.exp_cnt = ec; v.exp_idle = ei;
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent [NO];
        int rcvd [NO];
        logic [NO-1:0] src_xfer;
        int cyc;

        // cycle table for input channel 0: single word, fill, full+pop, drain
        tbl[0] = mk(1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 1'b0, 32'h0, 8'd0, 1'b1);
        tbl[1] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'hDEADBEEF, 8'd0, 1'b0);
        tbl[2] = mk(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, 8'd1, 1'b1);
        for (int k = 0; k < 8; k++)
            tbl[3+k] = mk(1'b1, 32'h100 + 32'(k), 1'b0, 1'b1, (k > 0), 32'h100, 8'd1, (k == 0));
        tbl[11] = mk(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 8'd1, 1'b0);
        tbl[12] = mk(1'b1, 32'h108, 1'b0, 1'b0, 1'b1, 32'h100, 8'd1, 1'b0);
        tbl[13] = mk(1'b1, 32'h108, 1'b1, 1'b0, 1'b1, 32'h100, 8'd1, 1'b0);
        tbl[14] = mk(1'b1, 32'h108, 1'b1, 1'b1, 1'b1, 32'h101, 8'd2, 1'b0);
        tbl[15] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h102, 8'd3, 1'b0);
        for (int k = 0; k < 6; k++)
            tbl[16+k] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b1, 32'h103 + 32'(k), 8'd4 + 8'(k), 1'b0);
        tbl[22] = mk(1'b0, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, 8'd10, 1'b1);

        // reset held with random inputs
        reset = 1'b0;
        for (int c = 0; c < 4; c++) begin
            ap_start        = 1'($urandom_range(1));
            clear_cnt       = 1'($urandom_range(1));
            bus.if_dout     = {$urandom, $urandom};
            bus.if_vld      = 2'($urandom_range(3));
            bus.k_din_ack   = 2'($urandom_range(3));
            bus.k_dout      = {$urandom, $urandom, $urandom};
            bus.k_dout_vld  = 3'($urandom_range(7));
            bus.if_din_ack  = 3'($urandom_range(7));
            step();
            check("rst_if_ack", bus.if_ack, {NI{1'b1}});
            check("rst_k_dout_ack", bus.k_dout_ack, {NO{1'b1}});
            check("rst_k_din_vld", bus.k_din_vld, '0);
            check("rst_if_din_vld", bus.if_din_vld, '0);
            check("rst_in_cnt", in_cnt, '0);
            check("rst_out_cnt", out_cnt, '0);
            check("rst_kernel_start", kernel_start, 1'b0);
            check("rst_idle", idle, 1'b1);
        end
        ap_start = 1'b0; clear_cnt = 1'b0;
        bus.if_vld = '0; bus.k_din_ack = '0; bus.k_dout_vld = '0; bus.if_din_ack = '0;
        bus.if_dout = '0; bus.k_dout = '0;
        reset = 1'b1;
        step();
        check("start_before", kernel_start, 1'b0);
        ap_start = 1'b1;
        step();
        ap_start = 1'b0;
        check("start_rise", kernel_start, 1'b1);
        step();
        check("start_sticky", kernel_start, 1'b1);

        // table-driven pass on input channel 0
        for (int r = 0; r < 23; r++) begin
            bus.if_vld[0] = tbl[r].vld;
            bus.if_dout[PB-1:0] = tbl[r].data;
            bus.k_din_ack[0] = tbl[r].kack;
            check($sformatf("tbl%0d_if_ack", r), bus.if_ack[0], tbl[r].exp_ack);
            check($sformatf("tbl%0d_k_din_vld", r), bus.k_din_vld[0], tbl[r].exp_kvld);
            if (tbl[r].exp_kvld)
                check($sformatf("tbl%0d_k_din", r), bus.k_din[PB-1:0], tbl[r].exp_kdin);
            check($sformatf("tbl%0d_in_cnt0", r), in_cnt[CB-1:0], tbl[r].exp_cnt);
            check($sformatf("tbl%0d_idle", r), idle, tbl[r].exp_idle);
            step();
        end

        // clear_cnt coinciding with a transfer
        bus.if_vld[0] = 1'b1; bus.if_dout[PB-1:0] = 32'h55; bus.k_din_ack[0] = 1'b0;
        step();
        bus.if_vld[0] = 1'b0;
        bus.k_din_ack[0] = 1'b1; clear_cnt = 1'b1;
        check("clr_k_din_vld", bus.k_din_vld[0], 1'b1);
        check("clr_k_din", bus.k_din[PB-1:0], 32'h55);
        step();
        clear_cnt = 1'b0; bus.k_din_ack[0] = 1'b0;
        check("clr_in_cnt0", in_cnt[CB-1:0], 8'd0);
        step();
        check("clr_in_cnt0_hold", in_cnt[CB-1:0], 8'd0);
        check("clr_idle", idle, 1'b1);

        // three output channels, random sink backpressure, 1000 words each
        for (int j = 0; j < NO; j++) begin sent[j] = 0; rcvd[j] = 0; end
        cyc = 0;
        while ((rcvd[0] < 1000 || rcvd[1] < 1000 || rcvd[2] < 1000) && cyc < 20000) begin
            for (int j = 0; j < NO; j++) begin
                if (!bus.k_dout_vld[j] && sent[j] < 1000 && $urandom_range(3) != 0) begin
                    bus.k_dout[j*PB +: PB] = 32'((j << 16) | sent[j]);
                    bus.k_dout_vld[j] = 1'b1;
                end
                bus.if_din_ack[j] = 1'($urandom_range(1));
            end
            for (int j = 0; j < NO; j++) begin
                src_xfer[j] = bus.k_dout_vld[j] & bus.k_dout_ack[j];
                if (bus.if_din_vld[j] && bus.if_din_ack[j]) begin
                    check($sformatf("mc_ch%0d_word%0d", j, rcvd[j]),
                          bus.if_din[j*PB +: PB], 32'((j << 16) | rcvd[j]));
                    rcvd[j]++;
                end
            end
            step();
            for (int j = 0; j < NO; j++)
                if (src_xfer[j]) begin
                    sent[j]++;
                    bus.k_dout_vld[j] = 1'b0;
                end
            cyc++;
        end
        bus.k_dout_vld = '0; bus.if_din_ack = '0;
        check("mc_done_in_budget", (cyc < 20000), 1'b1);
        step();
        for (int j = 0; j < NO; j++)
            check($sformatf("mc_out_cnt%0d", j), out_cnt[j*CB +: CB], 8'd232);
        check("mc_idle", idle, 1'b1);

        // reset with 5 words buffered on input channel 1
        bus.k_din_ack = '0;
        for (int k = 0; k < 5; k++) begin
            bus.if_vld[1] = 1'b1;
            bus.if_dout[PB +: PB] = 32'hA0 + 32'(k);
            step();
        end
        bus.if_vld[1] = 1'b0;
        check("pre_rst_k_din_vld1", bus.k_din_vld[1], 1'b1);
        check("pre_rst_idle", idle, 1'b0);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_k_din_vld", bus.k_din_vld, '0);
        check("mid_rst_idle", idle, 1'b1);
        check("mid_rst_if_ack", bus.if_ack, {NI{1'b1}});
        check("mid_rst_kernel_start", kernel_start, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        bus.k_din_ack = '1;
        for (int c = 0; c < 3; c++) begin
            step();
            check($sformatf("post_rst_k_din_vld_c%0d", c), bus.k_din_vld, '0);
            check($sformatf("post_rst_in_cnt_c%0d", c), in_cnt, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
